// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding/hazard unit.
// Holds the select-code constants, the register-address width, the
// shadow-entry payload and the forwarding-select priority helper.
package fwd_hazard_unit_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned SEL_W  = 2;

   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_REG   = 2'd0;
   localparam sel_t SEL_PRIOR = 2'd1;
   localparam sel_t SEL_WB    = 2'd2;

   // Destination info of one in-flight instruction.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rw;
      logic              regwr;
      logic              memtoreg;
   } shadow_t;

   // EX is the youngest producer, so it wins over MEM. A load in EX has no
   // result yet; that case is covered by the stall instead.
   function automatic sel_t fwd_sel(input logic ex_hit, input logic ex_load,
                                    input logic mem_hit);
      if (ex_hit && !ex_load) return SEL_PRIOR;
      if (mem_hit)            return SEL_WB;
      return SEL_REG;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle of the forwarding/hazard unit.
// master: decode stage (drives id_*/flush, receives selects and controls).
// slave : fwd_hazard_unit.
interface fwd_hazard_unit_if #(parameter int unsigned CNT_W = 16);
   import fwd_hazard_unit_pkg::*;

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_uses_rs;
   logic              id_uses_rt;
   logic              id_alusrc;
   logic [REG_AW-1:0] id_rw;
   logic              id_regwr;
   logic              id_memtoreg;
   logic              flush;
   sel_t              aluselectA;
   sel_t              aluselectB;
   logic              stall;
   logic              bubble;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_alusrc,
             id_rw, id_regwr, id_memtoreg, flush,
      input  aluselectA, aluselectB, stall, bubble, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_alusrc,
             id_rw, id_regwr, id_memtoreg, flush,
      output aluselectA, aluselectB, stall, bubble, stall_count
   );

endinterface

// File: rtl/fwd_hazard_unit_fwd_match.sv
// fwd_match: combinational hit detector.
// entry_i : shadow entry of one pipeline stage
// reg_i   : decode source register
// use_i   : the decode instruction actually reads reg_i
// hit_o   : entry will write reg_i ($0 never matches)
module fwd_match
   import fwd_hazard_unit_pkg::*;
(
   input  shadow_t           entry_i,
   input  logic [REG_AW-1:0] reg_i,
   input  logic              use_i,
   output logic              hit_o
);

   assign hit_o = use_i & entry_i.valid & entry_i.regwr &
                  (entry_i.rw == reg_i) & (reg_i != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding-select and load-use hazard generator.
// clk, reset : pipeline clock, async active-high reset
// bus        : decode fields and flush in; registered aluselectA/B,
//              combinational stall/bubble and saturating stall_count out.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)(
   input  logic              clk,
   input  logic              reset,
   fwd_hazard_unit_if.slave  bus
);

   // Only EX and MEM entries are kept: nothing downstream of MEM feeds a
   // select or the hazard check, the WB value is already on the bypass path.
   shadow_t          ex_q, ex_d, mem_q;
   sel_t             sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic use_rt_alu;
   logic ex_rs_hit, ex_rt_hit, mem_rs_hit, mem_rt_hit;
   logic stall_c, bubble_c;

   // rt only matters when it is an ALU operand, not when B is the immediate.
   assign use_rt_alu = bus.id_uses_rt & ~bus.id_alusrc;

   fwd_match u_ex_rs  (.entry_i(ex_q),  .reg_i(bus.id_rs), .use_i(bus.id_uses_rs), .hit_o(ex_rs_hit));
   fwd_match u_ex_rt  (.entry_i(ex_q),  .reg_i(bus.id_rt), .use_i(use_rt_alu),     .hit_o(ex_rt_hit));
   fwd_match u_mem_rs (.entry_i(mem_q), .reg_i(bus.id_rs), .use_i(bus.id_uses_rs), .hit_o(mem_rs_hit));
   fwd_match u_mem_rt (.entry_i(mem_q), .reg_i(bus.id_rt), .use_i(use_rt_alu),     .hit_o(mem_rt_hit));

   // Hazard detect, next shadow entry, next selects and counter.
   always_comb begin
      stall_c  = bus.id_valid & ~bus.flush & ex_q.memtoreg & (ex_rs_hit | ex_rt_hit);
      bubble_c = stall_c | bus.flush;

      ex_d = '0;
      if (!bubble_c) begin
         ex_d.valid    = bus.id_valid;
         ex_d.rw       = bus.id_rw;
         ex_d.regwr    = bus.id_regwr;
         ex_d.memtoreg = bus.id_memtoreg;
      end

      sel_a_d = SEL_REG;
      sel_b_d = SEL_REG;
      if (!bubble_c) begin
         sel_a_d = fwd_sel(ex_rs_hit, ex_q.memtoreg, mem_rs_hit);
         sel_b_d = fwd_sel(ex_rt_hit, ex_q.memtoreg, mem_rt_hit);
      end

      cnt_d = cnt_q;
      if (stall_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   // Shadow shift, select and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q    <= '0;
         mem_q   <= '0;
         sel_a_q <= SEL_REG;
         sel_b_q <= SEL_REG;
         cnt_q   <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.aluselectA  = sel_a_q;
   assign bus.aluselectB  = sel_b_q;
   assign bus.stall       = stall_c;
   assign bus.bubble      = bubble_c;
   assign bus.stall_count = cnt_q;

endmodule
